// File: rtl/audio_pkg.sv
// Types and constants shared by the codec serializer and deserializer datapaths.
package audio_pkg;

   localparam int AUDIO_DATA_WIDTH = 24;

   localparam logic LRCK_LEFT  = 1'b0;
   localparam logic LRCK_RIGHT = 1'b1;

   typedef struct packed {
      logic [AUDIO_DATA_WIDTH-1:0] left;
      logic [AUDIO_DATA_WIDTH-1:0] right;
   } stereo_sample_t;

   // What the shifter does on a recovered BCLK falling edge.
   typedef enum logic [1:0] {
      EV_NONE,
      EV_LEFT_START,
      EV_RIGHT_START,
      EV_SHIFT
   } slot_event_e;

endpackage

// File: rtl/stereo_sample_fifo.sv
// Synchronous FIFO of packed stereo pairs; the head entry is visible without a read latency.
module stereo_sample_fifo #(
   parameter int WIDTH = 48,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] pop_data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [AW:0]      level_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      level_q, level_d;
   logic             do_push, do_pop;

   assign full_o     = (level_q == (AW+1)'(DEPTH));
   assign empty_o    = (level_q == '0);
   assign level_o    = level_q;
   assign do_push    = push_i && !full_o;
   assign do_pop     = pop_i && !empty_o;
   assign pop_data_o = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage is left unreset so it maps onto distributed RAM.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/audio_dac_serializer.sv
// I2S transmitter for the WM8731 DAC, slaved to codec BCLK/DACLRCK oversampled on CLOCK_50.
module audio_dac_serializer
   import audio_pkg::*;
#(
   parameter int DATA_WIDTH  = AUDIO_DATA_WIDTH,
   parameter int FIFO_DEPTH  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                          CLOCK_50,
   input  logic                          KEY,
   input  logic                          write,
   input  logic [DATA_WIDTH-1:0]         writedata_left,
   input  logic [DATA_WIDTH-1:0]         writedata_right,
   output logic                          write_ready,
   input  logic                          AUD_BCLK,
   input  logic                          AUD_DACLRCK,
   output logic                          AUD_DACDAT,
   output logic                          underflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int CW = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] CNT_MAX = CW'(DATA_WIDTH - 1);

   logic [SYNC_STAGES-1:0]  bclk_sync_q, lrck_sync_q;
   logic                    bclk_s, lrck_s;
   logic                    bclk_dly_q, bclk_rise_q, bclk_fall_q;
   logic                    lrck_q, lrck_prev_q;
   logic [DATA_WIDTH-1:0]   shift_q, hold_q;
   logic [CW-1:0]           bit_cnt_q;
   logic                    armed_q, dacdat_q, underflow_q;
   slot_event_e             slot_ev;

   logic [2*DATA_WIDTH-1:0] fifo_rd;
   logic [DATA_WIDTH-1:0]   rd_left, rd_right;
   logic                    fifo_full, fifo_empty;

   stereo_sample_fifo #(
      .WIDTH (2*DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i       (CLOCK_50),
      .rst_ni      (KEY),
      .push_i      (write),
      .push_data_i ({writedata_left, writedata_right}),
      .pop_i       (slot_ev == EV_LEFT_START),
      .pop_data_o  (fifo_rd),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .level_o     (fifo_level)
   );

   assign rd_left     = fifo_rd[2*DATA_WIDTH-1:DATA_WIDTH];
   assign rd_right    = fifo_rd[DATA_WIDTH-1:0];
   assign write_ready = !fifo_full;
   assign AUD_DACDAT  = dacdat_q;
   assign underflow   = underflow_q;
   assign bclk_s      = bclk_sync_q[SYNC_STAGES-1];
   assign lrck_s      = lrck_sync_q[SYNC_STAGES-1];

   // A channel start waits for the first BCLK fall after the rise that saw LRCK move.
   always_comb begin
      slot_ev = EV_NONE;
      if (bclk_fall_q) begin
         if (lrck_q != lrck_prev_q)
            slot_ev = (lrck_q == LRCK_LEFT) ? EV_LEFT_START : EV_RIGHT_START;
         else
            slot_ev = EV_SHIFT;
      end
   end

   always_ff @(posedge CLOCK_50 or negedge KEY) begin
      if (!KEY) begin
         bclk_sync_q <= '0;
         lrck_sync_q <= '0;
         bclk_dly_q  <= 1'b0;
         bclk_rise_q <= 1'b0;
         bclk_fall_q <= 1'b0;
         lrck_q      <= LRCK_RIGHT;
         lrck_prev_q <= LRCK_RIGHT;
         shift_q     <= '0;
         hold_q      <= '0;
         bit_cnt_q   <= '0;
         armed_q     <= 1'b0;
         dacdat_q    <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], AUD_BCLK};
         lrck_sync_q <= {lrck_sync_q[SYNC_STAGES-2:0], AUD_DACLRCK};
         bclk_dly_q  <= bclk_s;
         bclk_rise_q <= bclk_s & ~bclk_dly_q;
         bclk_fall_q <= ~bclk_s & bclk_dly_q;
         underflow_q <= 1'b0;

         if (bclk_rise_q) begin
            lrck_q      <= lrck_s;
            lrck_prev_q <= lrck_q;
         end

         case (slot_ev)
            EV_LEFT_START: begin
               armed_q   <= 1'b1;
               bit_cnt_q <= CNT_MAX;
               if (!fifo_empty) begin
                  shift_q  <= rd_left;
                  hold_q   <= rd_right;
                  dacdat_q <= rd_left[DATA_WIDTH-1];
               end else begin
                  shift_q     <= '0;
                  hold_q      <= '0;
                  dacdat_q    <= 1'b0;
                  underflow_q <= 1'b1;
               end
            end
            EV_RIGHT_START: begin
               bit_cnt_q <= CNT_MAX;
               // Before the first left start after reset the hold register has no partner sample.
               if (armed_q) begin
                  shift_q  <= hold_q;
                  dacdat_q <= hold_q[DATA_WIDTH-1];
               end else begin
                  shift_q  <= '0;
                  dacdat_q <= 1'b0;
               end
            end
            EV_SHIFT: begin
               if (bit_cnt_q != '0) begin
                  shift_q   <= shift_q << 1;
                  dacdat_q  <= shift_q[DATA_WIDTH-2];
                  bit_cnt_q <= bit_cnt_q - 1'b1;
               end else begin
                  dacdat_q  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Directed bench: drives codec BCLK/LRCK, captures DACDAT on BCLK rises and checks each slot.
module tb_audio_dac_serializer;

   localparam int DW = 24;

   logic          CLOCK_50 = 1'b0;
   logic          KEY;
   logic          write;
   logic [DW-1:0] writedata_left, writedata_right;
   logic          write_ready;
   logic          AUD_BCLK, AUD_DACLRCK;
   logic          AUD_DACDAT;
   logic          underflow;
   logic [2:0]    fifo_level;

   audio_dac_serializer dut (
      .CLOCK_50        (CLOCK_50),
      .KEY             (KEY),
      .write           (write),
      .writedata_left  (writedata_left),
      .writedata_right (writedata_right),
      .write_ready     (write_ready),
      .AUD_BCLK        (AUD_BCLK),
      .AUD_DACLRCK     (AUD_DACLRCK),
      .AUD_DACDAT      (AUD_DACDAT),
      .underflow       (underflow),
      .fifo_level      (fifo_level)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Codec model: BCLK = 16 cycles, LRCK toggles on a BCLK fall every half_len BCLKs.
   int            half_len  = 32;
   int            slot_cnt  = 0;
   int            rise_idx  = 0;
   int            fall_cnt  = 0;
   int            nbits;
   logic [DW-1:0] cap       = '0;
   logic          tail      = 1'b0;
   logic          last_ch;
   logic [DW-1:0] last_word;
   logic          last_tail;

   initial begin
      AUD_BCLK    = 1'b0;
      AUD_DACLRCK = 1'b1;
      forever begin
         repeat (8) @(negedge CLOCK_50);
         AUD_BCLK = 1'b1;
         rise_idx++;
         nbits = (half_len - 1 > DW) ? DW : half_len - 1;
         if (rise_idx >= 2 && rise_idx < 2 + nbits)
            cap = {cap[DW-2:0], AUD_DACDAT};
         else if (rise_idx >= 2 + nbits)
            tail = tail | AUD_DACDAT;
         repeat (8) @(negedge CLOCK_50);
         AUD_BCLK = 1'b0;
         fall_cnt++;
         if (fall_cnt == half_len) begin
            last_ch     = AUD_DACLRCK;
            last_word   = cap;
            last_tail   = tail;
            slot_cnt++;
            AUD_DACLRCK = ~AUD_DACLRCK;
            fall_cnt    = 0;
            rise_idx    = 0;
            cap         = '0;
            tail        = 1'b0;
         end
      end
   end

   int   uf_count = 0;
   int   uf_wide  = 0;
   logic uf_prev  = 1'b0;

   initial forever begin
      @(negedge CLOCK_50);
      if (underflow === 1'b1) begin
         uf_count++;
         if (uf_prev) uf_wide++;
      end
      uf_prev = underflow;
   end

   // Returns on the first CLOCK_50 rise after the LRCK toggle.
   task automatic wait_slot_end();
      int s0 = slot_cnt;
      int n  = 0;
      while (slot_cnt == s0 && n < 2000) begin
         @(posedge CLOCK_50);
         n++;
      end
      chk("slot_timeout", 48'(slot_cnt == s0), 48'd0);
   endtask

   task automatic get_slot(output logic ch, output logic [DW-1:0] w, output logic t);
      wait_slot_end();
      ch = last_ch;
      w  = last_word;
      t  = last_tail;
      $display("slot %0d ch=%0d word=%06h tail=%0d level=%0d", slot_cnt, ch, w, t, fifo_level);
   endtask

   task automatic push_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
      @(negedge CLOCK_50);
      writedata_left  = l;
      writedata_right = r;
      write           = 1'b1;
      @(negedge CLOCK_50);
      write = 1'b0;
   endtask

   task automatic check_frame(input string tag, input logic [DW-1:0] l, input logic [DW-1:0] r);
      logic          ch, t;
      logic [DW-1:0] w;
      get_slot(ch, w, t);
      chk({tag, "_lch"}, 48'(ch), 48'd0);
      chk({tag, "_l"}, 48'(w), 48'(l));
      chk({tag, "_ltail"}, 48'(t), 48'd0);
      get_slot(ch, w, t);
      chk({tag, "_rch"}, 48'(ch), 48'd1);
      chk({tag, "_r"}, 48'(w), 48'(r));
      chk({tag, "_rtail"}, 48'(t), 48'd0);
   endtask

   logic [DW-1:0] fl [5] = '{24'h111111, 24'h2468AC, 24'h800000, 24'h7FFFFF, 24'hC0FFEE};
   logic [DW-1:0] fr [5] = '{24'hEEEEEE, 24'h000001, 24'h5A5A5A, 24'hFEDCBA, 24'h0BADF0};

   initial begin
      logic          ch, t;
      logic [DW-1:0] w;
      int            uf_base, wide_base, n;

      KEY = 1'b0; write = 1'b0; writedata_left = '0; writedata_right = '0;
      repeat (5) @(negedge CLOCK_50);
      chk("rst_ready", 48'(write_ready), 48'd1);
      chk("rst_level", 48'(fifo_level), 48'd0);
      chk("rst_dacdat", 48'(AUD_DACDAT), 48'd0);
      chk("rst_uf", 48'(underflow), 48'd0);
      repeat (5) @(negedge CLOCK_50);
      KEY = 1'b1;

      // Idle: two frames of zeros, one underflow pulse per left start.
      n = 0;
      do begin wait_slot_end(); n++; end while (last_ch != 1'b1 && n < 3);
      uf_base = uf_count; wide_base = uf_wide;
      check_frame("idle0", 24'h0, 24'h0);
      check_frame("idle1", 24'h0, 24'h0);
      chk("idle_uf_count", 48'(uf_count - uf_base), 48'd2);
      chk("idle_uf_width", 48'(uf_wide - wide_base), 48'd0);
      chk("idle_ready", 48'(write_ready), 48'd1);
      chk("idle_level", 48'(fifo_level), 48'd0);

      // Single pair pushed during a right slot.
      get_slot(ch, w, t);
      push_pair(24'hA5F00F, 24'h123456);
      chk("single_level_push", 48'(fifo_level), 48'd1);
      wait_slot_end();
      uf_base = uf_count;
      check_frame("single", 24'hA5F00F, 24'h123456);
      chk("single_uf", 48'(uf_count - uf_base), 48'd0);
      chk("single_level_after", 48'(fifo_level), 48'd0);

      // Full FIFO: five back-to-back writes, the fifth waits for the first pop.
      get_slot(ch, w, t);
      @(negedge CLOCK_50);
      for (int k = 0; k < 4; k++) begin
         writedata_left = fl[k]; writedata_right = fr[k]; write = 1'b1;
         @(negedge CLOCK_50);
      end
      chk("full_ready", 48'(write_ready), 48'd0);
      chk("full_level", 48'(fifo_level), 48'd4);
      writedata_left = fl[4]; writedata_right = fr[4];
      n = 0;
      while (!write_ready && n < 1500) begin
         @(negedge CLOCK_50);
         n++;
      end
      chk("full_holdoff_timeout", 48'(write_ready), 48'd1);
      chk("full_level_at_pop", 48'(fifo_level), 48'd3);
      @(negedge CLOCK_50);
      write = 1'b0;
      chk("full_level_5th", 48'(fifo_level), 48'd4);
      for (int k = 0; k < 5; k++) check_frame("full", fl[k], fr[k]);
      chk("full_level_drained", 48'(fifo_level), 48'd0);

      // Push in the exact cycle of a left-start pop, level 1.
      get_slot(ch, w, t);
      push_pair(24'h0F1E2D, 24'h3C4B5A);
      wait_slot_end();
      uf_base = uf_count;
      repeat (19) @(negedge CLOCK_50);
      writedata_left = 24'h600DF0; writedata_right = 24'h0D15EA; write = 1'b1;
      @(negedge CLOCK_50);
      write = 1'b0;
      chk("sim1_level", 48'(fifo_level), 48'd1);
      check_frame("sim1_a", 24'h0F1E2D, 24'h3C4B5A);
      chk("sim1_uf", 48'(uf_count - uf_base), 48'd0);
      check_frame("sim1_b", 24'h600DF0, 24'h0D15EA);

      // Same collision with an empty FIFO: underflow, pushed pair goes out a frame later.
      uf_base = uf_count; wide_base = uf_wide;
      repeat (19) @(negedge CLOCK_50);
      writedata_left = 24'h9ABCDE; writedata_right = 24'h13579B; write = 1'b1;
      @(negedge CLOCK_50);
      write = 1'b0;
      chk("sim0_level", 48'(fifo_level), 48'd1);
      repeat (3) @(negedge CLOCK_50);
      chk("sim0_uf", 48'(uf_count - uf_base), 48'd1);
      chk("sim0_uf_width", 48'(uf_wide - wide_base), 48'd0);
      check_frame("sim0_zero", 24'h0, 24'h0);
      check_frame("sim0_data", 24'h9ABCDE, 24'h13579B);

      // Reset asserted around left bit 10.
      get_slot(ch, w, t);
      push_pair(24'hFFFFFF, 24'h0F0F0F);
      push_pair(24'h222222, 24'h333333);
      wait_slot_end();
      repeat (170) @(negedge CLOCK_50);
      chk("mid_pre_dacdat", 48'(AUD_DACDAT), 48'd1);
      chk("mid_pre_level", 48'(fifo_level), 48'd1);
      KEY = 1'b0;
      #1;
      chk("mid_rst_dacdat", 48'(AUD_DACDAT), 48'd0);
      chk("mid_rst_level", 48'(fifo_level), 48'd0);
      repeat (10) @(negedge CLOCK_50);
      KEY = 1'b1;
      get_slot(ch, w, t);
      push_pair(24'hCAFE12, 24'h345BEE);
      get_slot(ch, w, t);
      chk("mid_right_ch", 48'(ch), 48'd1);
      chk("mid_right_zero", 48'(w), 48'd0);
      chk("mid_right_tail", 48'(t), 48'd0);
      check_frame("mid_resume", 24'hCAFE12, 24'h345BEE);

      // Short slots of 16 BCLKs: only the top 15 bits reach the codec.
      get_slot(ch, w, t);
      push_pair(24'hF0C3A5, 24'h5A3CF0);
      push_pair(24'h876543, 24'h13579F);
      wait_slot_end();
      half_len = 16;
      check_frame("short_a", 24'h7861, 24'h2D1E);
      check_frame("short_b", 24'h43B2, 24'h09AB);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
